// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl
//   Single-master MMIO sequencer between the CPU load/store stage and
//   NUM_SLAVES memory-mapped slaves. The block latches one CPU access,
//   broadcasts its address and write data, and strobes exactly one slave
//   through a one-hot read or write vector. It then waits for that slave's
//   done pulse and returns the read data, or an error, to the CPU.
//
// Ports
//   sys_clk, rst             clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata    access request, sampled only while idle
//   cpu_busy                 a transaction is in flight
//   cpu_ready                1-cycle completion pulse
//   cpu_rdata, cpu_err       completion data and status; held until the next completion
//   mmio_addr/write_data     latched address and write data, broadcast to all slaves
//   slv_work                 per-slave address claim, decoded by the slaves from mmio_addr
//   slv_read, slv_write      one-hot strobes
//   slv_done                 per-slave done pulse
//   slv_rdata                slave read data; slave i is at [32*i +: 32]
//   err_count                saturating count of error completions
//
// state  | meaning
// IDLE   | waiting for cpu_req
// DECODE | mmio_addr stable; pick the lowest-index claiming slave
// MISS   | no slave claimed; aligns the error response one cycle later
// WAIT   | strobe held; waiting for the selected done or the timeout
// RESP   | cpu_ready pulse with cpu_rdata/cpu_err
module mmio_bus_ctrl #(
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic                     cpu_busy,
  output logic                     cpu_ready,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_err,
  output logic [31:0]              mmio_addr,
  output logic [31:0]              mmio_write_data,
  input  logic [NUM_SLAVES-1:0]    slv_work,
  output logic [NUM_SLAVES-1:0]    slv_read,
  output logic [NUM_SLAVES-1:0]    slv_write,
  input  logic [NUM_SLAVES-1:0]    slv_done,
  input  logic [32*NUM_SLAVES-1:0] slv_rdata,
  output logic [15:0]              err_count
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_MISS,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  state, state_nxt;
  logic                    we_q;
  logic [SEL_W-1:0]        sel_q, sel_dec;
  logic [NUM_SLAVES-1:0]   sel_onehot;
  logic                    hit;
  logic [CNT_W-1:0]        cnt;
  logic                    cnt_tc;
  logic                    done_sel;
  logic [31:0]             rdata_sel;

  // Lowest claiming index wins, so scan from the top and let lower hits overwrite.
  always_comb begin
    sel_dec = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (slv_work[i]) sel_dec = SEL_W'(i);
    end
  end

  assign hit        = |slv_work;
  assign sel_onehot = NUM_SLAVES'(1) << sel_dec;
  assign done_sel   = slv_done[sel_q];
  assign rdata_sel  = slv_rdata[32*sel_q +: 32];
  // The down-counter is loaded with TIMEOUT-1 on entry to WAIT, so WAIT
  // lasts at most TIMEOUT cycles. cnt_tc marks the last permitted cycle.
  assign cnt_tc     = (cnt == '0);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_busy  = 1'b1;
    cpu_ready = 1'b0;
    case (state)
      S_IDLE: begin
        cpu_busy = 1'b0;
        if (cpu_req) state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = hit ? S_WAIT : S_MISS;
      S_MISS:   state_nxt = S_RESP;
      S_WAIT:   if (done_sel || cnt_tc) state_nxt = S_RESP;
      S_RESP: begin
        cpu_ready = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      we_q            <= 1'b0;
      sel_q           <= '0;
      cnt             <= '0;
      mmio_addr       <= '0;
      mmio_write_data <= '0;
      slv_read        <= '0;
      slv_write       <= '0;
      cpu_rdata       <= '0;
      cpu_err         <= 1'b0;
      err_count       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            we_q            <= cpu_we;
            mmio_addr       <= cpu_addr;
            mmio_write_data <= cpu_wdata;
          end
        end
        S_DECODE: begin
          if (hit) begin
            sel_q <= sel_dec;
            cnt   <= CNT_W'(TIMEOUT - 1);
            if (we_q) slv_write <= sel_onehot;
            else      slv_read  <= sel_onehot;
          end
        end
        S_MISS: begin
          cpu_rdata <= '0;
          cpu_err   <= 1'b1;
        end
        S_WAIT: begin
          // A done in the terminal cycle still counts as a successful completion.
          if (done_sel) begin
            slv_read  <= '0;
            slv_write <= '0;
            cpu_rdata <= we_q ? 32'h0 : rdata_sel;
            cpu_err   <= 1'b0;
          end else if (cnt_tc) begin
            slv_read  <= '0;
            slv_write <= '0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (cpu_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
